// File: rtl/md_pkg.sv
// Shared types for the multiply/divide sequencer: opcodes, FSM states, default latencies.
// MD_MADD_EN enables the MADD/MSUB accumulate opcodes.
package md_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_MADD  = 3'd6,
        OP_MSUB  = 3'd7
    } md_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

    // Ops that occupy the unit for a fixed latency before committing to HI/LO.
    function automatic logic is_long_op(input md_op_t op);
        logic r;
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: r = 1'b1;
`ifdef MD_MADD_EN
            OP_MADD, OP_MSUB:                   r = 1'b1;
`endif
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_div_op(input md_op_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 64-bit HI/LO result for a multiply/divide op, including the
// divide-by-zero and signed-overflow (0x80000000 / -1) results.
module md_arith
    import md_pkg::*;
(
    input  md_op_t      i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
    output logic [63:0] o_res
);

    logic signed [63:0] w_prod_s;
    logic        [63:0] w_prod_u;
    logic signed [31:0] w_sq;
    logic signed [31:0] w_sr;
    logic        [31:0] w_uq;
    logic        [31:0] w_ur;
    logic               w_div0;
    logic               w_ovf;

    always_comb begin
        w_prod_s = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
        w_prod_u = {32'd0, i_a} * {32'd0, i_b};
        w_div0   = (i_b == 32'd0);
        w_ovf    = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);
        w_sq     = $signed(i_a) / $signed(i_b);
        w_sr     = $signed(i_a) % $signed(i_b);
        w_uq     = i_a / i_b;
        w_ur     = i_a % i_b;

        o_res = {i_hi, i_lo};
        case (i_op)
            OP_MULT:  o_res = w_prod_s;
            OP_MULTU: o_res = w_prod_u;
            OP_DIV: begin
                // The overflow case is pinned explicitly since the native divide is undefined there.
                if (w_div0)     o_res = {i_a, 32'hFFFF_FFFF};
                else if (w_ovf) o_res = {32'd0, 32'h8000_0000};
                else            o_res = {w_sr, w_sq};
            end
            OP_DIVU: begin
                if (w_div0) o_res = {i_a, 32'hFFFF_FFFF};
                else        o_res = {w_ur, w_uq};
            end
            OP_MADD:  o_res = {i_hi, i_lo} + w_prod_s;
            OP_MSUB:  o_res = {i_hi, i_lo} - w_prod_s;
            default:  o_res = {i_hi, i_lo};
        endcase
    end

endmodule

// File: rtl/md_unit_ctrl.sv
// Multi-cycle multiply/divide sequencer: latches operands, counts fixed latency, commits HI/LO.
// Handshake: a start pulse is accepted only in IDLE without cancel; busy high means later starts are dropped.
// MD_MADD_EN enables MADD/MSUB (MULT latency, accumulate into HI/LO at commit).
module md_unit_ctrl
    import md_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        cancel,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output state_t      dbg_state
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    md_op_t           r_op;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    md_op_t           w_op;
    logic             w_latch;
    logic             w_commit;
    logic             w_mthi;
    logic             w_mtlo;
    logic [63:0]      w_res;

    assign w_op = md_op_t'(md_op);

    md_arith u_arith (
        .i_op  (r_op),
        .i_a   (r_a),
        .i_b   (r_b),
        .i_hi  (r_hi),
        .i_lo  (r_lo),
        .o_res (w_res)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_latch     = 1'b0;
        w_commit    = 1'b0;
        w_mthi      = 1'b0;
        w_mtlo      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !cancel) begin
                    if (is_long_op(w_op)) begin
                        w_latch     = 1'b1;
                        w_state_nxt = RUN;
                        w_count_nxt = is_div_op(w_op) ? DIV_CNT : MULT_CNT;
                    end else if (w_op == OP_MTHI) begin
                        w_mthi = 1'b1;
                    end else if (w_op == OP_MTLO) begin
                        w_mtlo = 1'b1;
                    end
                end
            end
            RUN: begin
                // cancel beats the final-cycle commit
                if (cancel) begin
                    w_state_nxt = IDLE;
                    w_count_nxt = '0;
                end else if (r_count == '0) begin
                    w_commit    = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_count_nxt = r_count - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_count <= '0;
            r_op    <= OP_MULT;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            if (w_latch) begin
                r_op <= w_op;
                r_a  <= rs_val;
                r_b  <= rt_val;
            end
            if (w_commit) begin
                r_hi <= w_res[63:32];
                r_lo <= w_res[31:0];
            end
            if (w_mthi) r_hi <= rs_val;
            if (w_mtlo) r_lo <= rs_val;
        end
    end

    assign busy      = (r_state == RUN);
    assign hi        = r_hi;
    assign lo        = r_lo;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Self-checking bench for md_unit_ctrl: directed vector table, corner sequences, random ops vs a reference model.
module tb_md_unit_ctrl;
    import md_pkg::*;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        cancel;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    state_t      dbg_state;

    int n_tests;
    int n_fail;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    md_unit_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .md_op     (md_op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .cancel    (cancel),
        .busy      (busy),
        .hi        (hi),
        .lo        (lo),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // reference model, written from the arithmetic rules
    function automatic int exp_lat(input logic [2:0] op);
        case (op)
            3'd0, 3'd1: return MULT_LAT;
            3'd2, 3'd3: return DIV_LAT;
`ifdef MD_MADD_EN
            3'd6, 3'd7: return MULT_LAT;
`endif
            default:    return 0;
        endcase
    endfunction

    task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r, p, acc;
        longint unsigned ua, ub, uq, ur, up;
        logic [63:0] v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd0: begin p = sa * sb; v = p; m_hi = v[63:32]; m_lo = v[31:0]; end
            3'd1: begin up = ua * ub; v = up; m_hi = v[63:32]; m_lo = v[31:0]; end
            3'd2: begin
                if (b == 32'd0) begin m_hi = a; m_lo = 32'hFFFF_FFFF; end
                else begin
                    q = sa / sb; r = sa % sb;
                    v = q; m_lo = v[31:0];
                    v = r; m_hi = v[31:0];
                end
            end
            3'd3: begin
                if (b == 32'd0) begin m_hi = a; m_lo = 32'hFFFF_FFFF; end
                else begin
                    uq = ua / ub; ur = ua % ub;
                    v = uq; m_lo = v[31:0];
                    v = ur; m_hi = v[31:0];
                end
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
`ifdef MD_MADD_EN
            3'd6, 3'd7: begin
                p = sa * sb;
                acc = longint'({m_hi, m_lo});
                acc = (op == 3'd6) ? acc + p : acc - p;
                v = acc; m_hi = v[63:32]; m_lo = v[31:0];
            end
`endif
            default: ;
        endcase
    endtask

    // driver: one start pulse, then count busy cycles and watch that hi/lo hold while busy
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic held);
        logic [31:0] h0, l0;
        @(negedge clk);
        h0 = hi; l0 = lo;
        start = 1'b1; md_op = op; rs_val = a; rt_val = b;
        @(posedge clk); #1;
        start = 1'b0; rs_val = $urandom; rt_val = $urandom;
        lat = 0; held = 1'b1;
        while (busy === 1'b1 && lat < 64) begin
            lat++;
            if (hi !== h0 || lo !== l0) held = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic run_check(input string tag, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b);
        int lat;
        logic held;
        issue(op, a, b, lat, held);
        model_op(op, a, b);
        check32({tag, "_lat"}, lat, exp_lat(op));
        check32({tag, "_hold"}, {31'd0, held}, 32'd1);
        check32({tag, "_hi"}, hi, m_hi);
        check32({tag, "_lo"}, lo, m_lo);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e_hi;
        logic [31:0] e_lo;
        int          e_lat;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int lat;
        logic held;
        logic [31:0] pick[6];

        n_tests = 0; n_fail = 0;
        m_hi = '0; m_lo = '0;
        start = 1'b0; md_op = '0; rs_val = '0; rt_val = '0; cancel = 1'b0;
        reset_n = 1'b0;

        vecs[0] = '{3'd0, 32'hFFFF_FFFE, 32'd3,          32'hFFFF_FFFF, 32'hFFFF_FFFA, MULT_LAT};
        vecs[1] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MULT_LAT};
        vecs[2] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, MULT_LAT};
        vecs[3] = '{3'd3, 32'd7,         32'd2,          32'd1,         32'd3,         DIV_LAT};
        vecs[4] = '{3'd2, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT};
        vecs[5] = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, DIV_LAT};
        vecs[6] = '{3'd2, 32'd5,         32'd0,          32'd5,         32'hFFFF_FFFF, DIV_LAT};
        vecs[7] = '{3'd3, 32'd9,         32'd0,          32'd9,         32'hFFFF_FFFF, DIV_LAT};
        vecs[8] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, DIV_LAT};

        #12;
        check32("reset_busy", {31'd0, busy}, 32'd0);
        check32("reset_hi", hi, 32'd0);
        check32("reset_lo", lo, 32'd0);
        check32("reset_state", {31'd0, dbg_state}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // directed table
        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, lat, held);
            check32($sformatf("vec%0d_lat", i), lat, vecs[i].e_lat);
            check32($sformatf("vec%0d_hi", i), hi, vecs[i].e_hi);
            check32($sformatf("vec%0d_lo", i), lo, vecs[i].e_lo);
        end
        m_hi = hi; m_lo = lo;

        // MTHI / MTLO write at the start edge with no busy
        run_check("mthi", 3'd4, 32'h0000_1234, 32'd0);
        run_check("mtlo", 3'd5, 32'h0000_5678, 32'd0);

        // second start while busy is dropped
        @(negedge clk);
        start = 1'b1; md_op = 3'd0; rs_val = 32'd3; rt_val = 32'd4;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (busy === 1'b1 && lat < 64) begin
            lat++;
            if (lat == 2) begin
                @(negedge clk);
                start = 1'b1; md_op = 3'd3; rs_val = 32'd100; rt_val = 32'd7;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        model_op(3'd0, 32'd3, 32'd4);
        check32("busy_start_lat", lat, MULT_LAT);
        check32("busy_start_hi", hi, m_hi);
        check32("busy_start_lo", lo, m_lo);
        repeat (DIV_LAT + 2) @(posedge clk);
        #1;
        check32("busy_start_idle", {31'd0, busy}, 32'd0);
        check32("busy_start_lo2", lo, m_lo);

        // cancel during RUN: busy drops next edge, no commit
        run_check("pre_cxl_hi", 3'd4, 32'hAAAA_0001, 32'd0);
        run_check("pre_cxl_lo", 3'd5, 32'h5555_0002, 32'd0);
        @(negedge clk);
        start = 1'b1; md_op = 3'd2; rs_val = 32'd100; rt_val = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        check32("cxl_busy", {31'd0, busy}, 32'd0);
        repeat (DIV_LAT + 2) @(posedge clk);
        #1;
        check32("cxl_hi", hi, m_hi);
        check32("cxl_lo", lo, m_lo);

        // cancel on the final RUN cycle still wins
        @(negedge clk);
        start = 1'b1; md_op = 3'd0; rs_val = 32'd7; rt_val = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (MULT_LAT - 1) @(posedge clk);
        @(negedge clk);
        check32("cxl_last_busy_pre", {31'd0, busy}, 32'd1);
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        check32("cxl_last_busy", {31'd0, busy}, 32'd0);
        check32("cxl_last_hi", hi, m_hi);
        check32("cxl_last_lo", lo, m_lo);

        // start together with cancel in IDLE is ignored
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; md_op = 3'd4; rs_val = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
        check32("sc_mthi_hi", hi, m_hi);
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; md_op = 3'd0; rs_val = 32'd2; rt_val = 32'd2;
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
        check32("sc_mult_busy", {31'd0, busy}, 32'd0);

        // accumulate ops
        run_check("madd_hi0", 3'd4, 32'd0, 32'd0);
        run_check("madd_lo10", 3'd5, 32'd10, 32'd0);
        run_check("madd", 3'd6, 32'd2, 32'd3);
`ifdef MD_MADD_EN
        check32("madd_lo16", lo, 32'd16);
`else
        check32("op6_noop_lo", lo, 32'd10);
`endif
        run_check("msub", 3'd7, 32'hFFFF_FFFF, 32'd4);

        // randomized ops against the model
        pick[0] = 32'h8000_0000; pick[1] = 32'hFFFF_FFFF; pick[2] = 32'd0;
        pick[3] = 32'd1;         pick[4] = 32'h7FFF_FFFF; pick[5] = 32'd2;
        for (int k = 0; k < 60; k++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 5)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 5)] : $urandom;
            run_check($sformatf("rnd%0d_op%0d", k, op), op, a, b);
        end

        // asynchronous reset mid-RUN clears everything at once
        run_check("pre_rst", 3'd4, 32'hCAFE_F00D, 32'd0);
        @(negedge clk);
        start = 1'b1; md_op = 3'd2; rs_val = 32'd50; rt_val = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check32("rst_busy", {31'd0, busy}, 32'd0);
        check32("rst_hi", hi, 32'd0);
        check32("rst_lo", lo, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        m_hi = '0; m_lo = '0;
        repeat (DIV_LAT + 2) @(posedge clk);
        #1;
        check32("rst_after_lo", lo, 32'd0);
        run_check("post_rst", 3'd1, 32'd6, 32'd7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
